fp_mul_iter: RTL

- Parametrised, multi-cycle IEEE-754-style floating-point multiplier. Successor to the combinational half-precision multiplier.
- Mantissa product is formed by an iterative radix-4 Booth engine that retires one Booth digit per clock. A single normalise/round stage follows it.
- Valid/ready handshakes on input and output. Fixed latency that does not depend on the data.
- Default configuration is binary16. Sits between operand registers and the FP result writeback path.

---
 rtl/fp_mul_if.sv | 27 ++
 rtl/fp_mul_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for the iterative floating-point multiplier.
// The master side issues operands and accepts results; the slave side is the multiplier.
interface fp_mul_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_flags
  );
endinterface

// File: rtl/fp_mul_iter.sv
// Multi-cycle IEEE-754-style multiplier: radix-4 Booth mantissa engine (one digit per clock)
// followed by a single normalise/round/pack stage. Subnormals flush to zero; RNE rounding.
module fp_mul_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic     clk,
  input logic     rst,
  fp_mul_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int NIT   = (MAN_W + 3) / 2;
  localparam int PW    = 2 * (MAN_W + 1);
  localparam int ACC_W = MAN_W + 2 * NIT + 4;
  localparam int MB_W  = 2 * NIT + 1;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(NIT + 1);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [W-1:0]             a_q, a_d;
  logic [W-1:0]             b_q, b_d;
  logic [MB_W-1:0]          mb_q, mb_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [W-1:0]             out_p_q, out_p_d;
  logic [3:0]               out_flags_q, out_flags_d;

  logic [EXP_W-1:0]         a_exp, b_exp;
  logic                     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
  logic [PW-1:0]            prod;
  logic [PW-2:0]            norm;
  logic                     guard, rnd, sticky;
  logic [MAN_W:0]           rounded;
  logic signed [EW-1:0]     exp_r;
  logic [W-1:0]             res;
  logic [3:0]               res_flags;
  logic                     acc_hi_unused;

  // Radix-4 Booth digit selection: {0, +-M, +-2M} from a multiplier triplet.
  function automatic logic signed [ACC_W-1:0] booth_pp(input logic [2:0] trip,
                                                       input logic [MAN_W:0] m);
    logic signed [ACC_W-1:0] mm;
    mm = signed'({{(ACC_W-MAN_W-1){1'b0}}, m});
    case (trip)
      3'b001, 3'b010: booth_pp = mm;
      3'b011:         booth_pp = mm <<< 1;
      3'b100:         booth_pp = -(mm <<< 1);
      3'b101, 3'b110: booth_pp = -mm;
      default:        booth_pp = '0;
    endcase
  endfunction

  // Round-to-nearest-even; MSB of the result is the carry out of the fraction.
  function automatic logic [MAN_W:0] rne_round(input logic [MAN_W-1:0] frac,
                                               input logic g, input logic r, input logic s);
    logic up;
    up = g & (r | s | frac[0]);
    rne_round = {1'b0, frac} + {{MAN_W{1'b0}}, up};
  endfunction

  // Saturate out-of-range exponents to Inf / flushed zero, else pack a normal result.
  function automatic logic [W+3:0] sat_pack(input logic s, input logic signed [EW-1:0] e,
                                            input logic [MAN_W-1:0] f, input logic inexact);
    if (!e[EW-1] && ($unsigned(e) >= EXP_MAX))
      sat_pack = {4'b0101, s, EXP_ONES, {MAN_W{1'b0}}};
    else if (e[EW-1] || (e == '0))
      sat_pack = {4'b0011, s, {(W-1){1'b0}}};
    else
      sat_pack = {3'b000, inexact, s, e[EXP_W-1:0], f};
  endfunction

  assign acc_hi_unused = ^acc_q[ACC_W-1:PW];

  always_comb begin
    a_exp  = a_q[W-2:MAN_W];
    b_exp  = b_q[W-2:MAN_W];
    a_nan  = (&a_exp) && (|a_q[MAN_W-1:0]);
    b_nan  = (&b_exp) && (|b_q[MAN_W-1:0]);
    a_inf  = (&a_exp) && !(|a_q[MAN_W-1:0]);
    b_inf  = (&b_exp) && !(|b_q[MAN_W-1:0]);
    a_zero = !(|a_exp);
    b_zero = !(|b_exp);
    sign   = a_q[W-1] ^ b_q[W-1];

    // Product lies in [1,4); normalise so the hidden one falls just above norm.
    prod    = acc_q[PW-1:0];
    norm    = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    guard   = norm[MAN_W];
    rnd     = norm[MAN_W-1];
    sticky  = |norm[MAN_W-2:0];
    rounded = rne_round(norm[PW-2:MAN_W+1], guard, rnd, sticky);
    exp_r   = EW'(a_exp) + EW'(b_exp) - EW'(BIAS) + EW'(prod[PW-1]) + EW'(rounded[MAN_W]);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      {res_flags, res} = {4'b1000, QNAN};
    else if (a_inf || b_inf)
      {res_flags, res} = {4'b0000, sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (a_zero || b_zero)
      {res_flags, res} = {4'b0000, sign, {(W-1){1'b0}}};
    else
      {res_flags, res} = sat_pack(sign, exp_r, rounded[MAN_W-1:0], guard | rnd | sticky);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_flags_d = out_flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          mb_d       = MB_W'({2'b01, bus.in_b[MAN_W-1:0], 1'b0});
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = MUL;
        end
      end
      MUL: begin
        // mb_q[2:0] is the current triplet; the multiplier shifts down one digit per step.
        acc_d = acc_q + (booth_pp(mb_q[2:0], {1'b1, a_q[MAN_W-1:0]}) <<< {cnt_q, 1'b0});
        mb_d  = mb_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NIT - 1))
          state_d = NORM;
      end
      NORM: begin
        out_p_d     = res;
        out_flags_d = res_flags;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_flags = out_flags_q;
endmodule
